// File: rtl/mac_acc_seq.sv
// -----------------------------------------------------------------------------
// mac_acc_seq
//
// Parametrised neuron accumulator. Each frame is TERMS valid product beats plus
// one signed bias (sampled on the frame's first beat). The frame sum is
// published on a registered output together with a one-cycle valid pulse.
// Gaps in din_valid stall the accumulation; frames may run back to back.
//
// Optional feature (compile-time macro):
//   ACC_SAT_EN  - every addition saturates to the signed ACC_W range instead of
//                 wrapping modulo 2^ACC_W. The clamp is applied per step.
//
// Parameters:
//   DIN_W   width of signed product input din
//   BIAS_W  width of signed bias input
//   ACC_W   width of accumulator and sum (>= DIN_W, >= BIAS_W)
//   TERMS   valid beats per frame (>= 1)
//   CNT_W   width of the term counter output
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clr        synchronous abort; drops the partial frame and any beat this cycle
//   din_valid  din carries a product term this cycle
//   din        signed product term
//   bias       signed bias, used only on the first beat of a frame
//   sum        signed frame result, held until the next result
//   sum_valid  one-cycle pulse marking a new sum
//   busy       high while a frame is partially accumulated
//   term_cnt   beats accepted in the current frame (0..TERMS-1)
// -----------------------------------------------------------------------------
module mac_acc_seq #(
  parameter int DIN_W  = 20,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 24,
  parameter int TERMS  = 16,
  parameter int CNT_W  = $clog2(TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              din_valid,
  input  logic [DIN_W-1:0]  din,
  input  logic [BIAS_W-1:0] bias,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  term_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Count value held while waiting for the final beat of a frame.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Two's-complement add of two ACC_W values; wraps, or clamps when
  // saturation is compiled in.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
`ifdef ACC_SAT_EN
    logic [ACC_W:0] full;
    full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Overflow shows up as the guard bit disagreeing with the result sign;
    // the guard bit then holds the true sign of the unbounded sum.
    if (full[ACC_W] != full[ACC_W-1]) begin
      return full[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    return full[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Operands sign-extended to accumulator width.
  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] bias_ext;

  assign din_ext  = ACC_W'($signed(din));
  assign bias_ext = ACC_W'($signed(bias));

  // State registers and their next-state values.
  state_e           state_q,     state_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [ACC_W-1:0] sum_q,       sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             busy_q,      busy_d;
  logic [CNT_W-1:0] term_cnt_q,  term_cnt_d;

  // First-beat and continuing partial sums, computed once and shared.
  logic [ACC_W-1:0] first_sum;
  logic [ACC_W-1:0] next_sum;

  assign first_sum = acc_add(bias_ext, din_ext);
  assign next_sum  = acc_add(acc_q, din_ext);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    term_cnt_d  = term_cnt_q;

    if (clr) begin
      // Abort beats any same-cycle beat, including the last one; sum is kept.
      state_d    = IDLE;
      acc_d      = '0;
      term_cnt_d = '0;
    end else if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (TERMS == 1) begin
            // Single-term frames finish on their only beat.
            sum_d       = first_sum;
            sum_valid_d = 1'b1;
          end else begin
            acc_d      = first_sum;
            term_cnt_d = CNT_W'(1);
            state_d    = ACCUM;
          end
        end
        ACCUM: begin
          if (term_cnt_q == LAST_CNT) begin
            sum_d       = next_sum;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            term_cnt_d  = '0;
            state_d     = IDLE;
          end else begin
            acc_d      = next_sum;
            term_cnt_d = term_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          acc_d      = '0;
          term_cnt_d = '0;
        end
      endcase
    end

    // busy is registered from the next state so it is glitch-free.
    busy_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before the edge, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      term_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      busy_q      <= busy_d;
      term_cnt_q  <= term_cnt_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = busy_q;
  assign term_cnt  = term_cnt_q;

endmodule

// File: tb/tb_mac_acc_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_acc_seq
//
// Self-checking bench for mac_acc_seq at default parameters. Expected frame
// results are pushed to a scoreboard queue when a frame is driven; a monitor
// pops and compares them whenever sum_valid pulses. Scenario tasks check
// control outputs (busy, term_cnt, pulse timing) inline.
// -----------------------------------------------------------------------------
module tb_mac_acc_seq;

  localparam int DIN_W  = 20;
  localparam int BIAS_W = 8;
  localparam int ACC_W  = 24;
  localparam int TERMS  = 16;
  localparam int CNT_W  = $clog2(TERMS + 1);

  logic              clk;
  logic              rst;
  logic              clr;
  logic              din_valid;
  logic [DIN_W-1:0]  din;
  logic [BIAS_W-1:0] bias;
  logic [ACC_W-1:0]  sum;
  logic              sum_valid;
  logic              busy;
  logic [CNT_W-1:0]  term_cnt;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] exp_q[$];
  int cyc            = 0;
  int pulses         = 0;
  int last_pulse_cyc = -1;
  int prev_pulse_cyc = -1;

  mac_acc_seq #(
    .DIN_W (DIN_W),
    .BIAS_W(BIAS_W),
    .ACC_W (ACC_W),
    .TERMS (TERMS),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .din_valid(din_valid),
    .din      (din),
    .bias     (bias),
    .sum      (sum),
    .sum_valid(sum_valid),
    .busy     (busy),
    .term_cnt (term_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: samples just after each rising edge; every pulse must match the
  // oldest outstanding expected result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sum_valid === 1'b1) begin
        pulses++;
        prev_pulse_cyc = last_pulse_cyc;
        last_pulse_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: sum=%h at cycle %0d, no result expected", sum, cyc);
        end else begin
          logic [ACC_W-1:0] exp_sum;
          exp_sum = exp_q.pop_front();
          if (sum !== exp_sum) begin
            errors++;
            $display("FAIL frame_sum: got %h expected %h", sum, exp_sum);
          end
        end
      end
    end
  end

  // Present one beat at the falling edge; it is accepted on the next rising edge.
  task automatic drive_beat(input logic [BIAS_W-1:0] b, input logic [DIN_W-1:0] d,
                            input logic c);
    @(negedge clk);
    din_valid = 1'b1;
    din       = d;
    bias      = b;
    clr       = c;
  endtask

  // Deassert din_valid/clr and let n (>= 1) falling edges go by.
  task automatic idle_cycles(input int n);
    @(negedge clk);
    din_valid = 1'b0;
    clr       = 1'b0;
    din       = '0;
    bias      = '0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Drive a complete frame; the bias input carries junk except on beat 1.
  task automatic drive_frame(input logic [BIAS_W-1:0] b, input logic [DIN_W-1:0] d);
    for (int i = 0; i < TERMS; i++) begin
      drive_beat((i == 0) ? b : 8'h5A, d, 1'b0);
    end
  endtask

  // After the last beat has been driven: the pulse must appear right after
  // the accepting edge.
  task automatic check_pulse_now(input string name);
    @(posedge clk);
    #2;
    checks++;
    if (last_pulse_cyc !== cyc) begin
      errors++;
      $display("FAIL %s_latency: pulse at cycle %0d, required %0d", name, last_pulse_cyc, cyc);
    end
  endtask

  task automatic check_pulses(input string name, input int exp_cnt);
    checks++;
    if (pulses !== exp_cnt) begin
      errors++;
      $display("FAIL %s_pulses: count %0d, required %0d", name, pulses, exp_cnt);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || term_cnt !== '0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b term_cnt=%0d, required busy=0 term_cnt=0",
               name, busy, term_cnt);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    clr       = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    bias      = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sum !== '0 || sum_valid !== 1'b0 || busy !== 1'b0 || term_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: sum=%h sum_valid=%b busy=%b term_cnt=%0d, required all 0",
               sum, sum_valid, busy, term_cnt);
    end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    int p0 = pulses;
    exp_q.push_back(24'd21);
    drive_beat(8'd5, 20'd1, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || term_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL basic_first_beat: busy=%b term_cnt=%0d, required busy=1 term_cnt=1",
               busy, term_cnt);
    end
    for (int i = 1; i < TERMS; i++) drive_beat(8'h33, 20'd1, 1'b0);
    check_pulse_now("basic");
    idle_cycles(4);
    check_idle_outputs("basic");
    check_pulses("basic", p0 + 1);
  endtask

  task automatic test_gaps();
    int p0 = pulses;
    exp_q.push_back(24'hFFFF70);
    for (int i = 0; i < TERMS; i++) begin
      drive_beat((i == 0) ? 8'h80 : 8'h7F, 20'hFFFFF, 1'b0);
      if ($urandom_range(0, 1) == 1 || i == 0 || i == 14) begin
        idle_cycles($urandom_range(1, 4));
        if (i < TERMS - 1) begin
          checks++;
          if (term_cnt !== CNT_W'(i + 1) || busy !== 1'b1) begin
            errors++;
            $display("FAIL gaps_hold: term_cnt=%0d busy=%b, required term_cnt=%0d busy=1",
                     term_cnt, busy, i + 1);
          end
        end
      end
    end
    idle_cycles(4);
    check_idle_outputs("gaps");
    check_pulses("gaps", p0 + 1);
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
    exp_q.push_back(24'd32);
    exp_q.push_back(24'd49);
    drive_frame(8'd0, 20'd2);
    drive_frame(8'd1, 20'd3);
    check_pulse_now("b2b");
    checks++;
    if (last_pulse_cyc - prev_pulse_cyc !== TERMS) begin
      errors++;
      $display("FAIL b2b_spacing: %0d cycles between pulses, required %0d",
               last_pulse_cyc - prev_pulse_cyc, TERMS);
    end
    idle_cycles(4);
    check_pulses("b2b", p0 + 2);
  endtask

  task automatic test_reset_mid_frame();
    int p0 = pulses;
    for (int i = 0; i < 7; i++) drive_beat((i == 0) ? 8'd0 : 8'h11, 20'd4, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (term_cnt !== CNT_W'(7)) begin
      errors++;
      $display("FAIL rstmid_count: term_cnt=%0d, required 7", term_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sum !== '0 || sum_valid !== 1'b0 || busy !== 1'b0 || term_cnt !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: sum=%h sum_valid=%b busy=%b term_cnt=%0d, required all 0",
               sum, sum_valid, busy, term_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(24'd64);
    drive_frame(8'd0, 20'd4);
    check_pulse_now("rstmid");
    idle_cycles(3);
    check_pulses("rstmid", p0 + 1);
  endtask

  task automatic test_clr();
    int p0 = pulses;
    // Abort on beat 10: the beat carried with clr is dropped too.
    for (int i = 0; i < 9; i++) drive_beat((i == 0) ? 8'd2 : 8'h44, 20'd1, 1'b0);
    drive_beat(8'h44, 20'd1, 1'b1);
    idle_cycles(1);
    checks++;
    if (busy !== 1'b0 || term_cnt !== '0 || sum !== 24'd64) begin
      errors++;
      $display("FAIL clr_abort: busy=%b term_cnt=%0d sum=%h, required busy=0 term_cnt=0 sum=000040",
               busy, term_cnt, sum);
    end
    // Abort on the last beat suppresses the result.
    for (int i = 0; i < TERMS - 1; i++) drive_beat((i == 0) ? 8'd9 : 8'h44, 20'd7, 1'b0);
    drive_beat(8'h44, 20'd7, 1'b1);
    idle_cycles(3);
    check_idle_outputs("clr_last");
    check_pulses("clr_suppress", p0);
    checks++;
    if (sum !== 24'd64) begin
      errors++;
      $display("FAIL clr_hold_sum: sum=%h, required 000040", sum);
    end
    exp_q.push_back(24'd18);
    drive_frame(8'd2, 20'd1);
    check_pulse_now("clr");
    idle_cycles(3);
    check_pulses("clr", p0 + 1);
  endtask

  task automatic test_overflow();
    int p0 = pulses;
`ifdef ACC_SAT_EN
    exp_q.push_back(24'h7FFFFF);
`else
    exp_q.push_back(24'h80006F);
`endif
    drive_frame(8'd127, 20'h7FFFF);
    check_pulse_now("overflow");
    idle_cycles(3);
    check_pulses("overflow", p0 + 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_clr();
    test_overflow();
    idle_cycles(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
